// File: rtl/bnn_seq_sched_if.sv
// Sample-in / class-out handshake bundle for the BNN sample scheduler.
// The scheduler uses the slave side; the sample source and result consumer use the master side.
interface bnn_seq_sched_if #(
    parameter int N  = 11,
    parameter int B  = 4,
    parameter int KW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [N*B-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [KW-1:0]  out_klass;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_klass
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_klass
    );
endinterface

// File: rtl/bnn_seq_sched.sv
// Scheduler for one sequential BNN core: latch a sample, restart the core, wait its fixed
// latency, capture the class and hand it out on a valid/ready port.
module bnn_seq_sched #(
    parameter int N   = 11,
    parameter int B   = 4,
    parameter int C   = 6,
    parameter int LAT = 48,
    parameter int CW  = 16,
    localparam int KW = (C > 1) ? $clog2(C) : 1
) (
    input  logic              clk,
    input  logic              rst,
    bnn_seq_sched_if.slave    bus,
    output logic              core_rst,
    output logic [N*B-1:0]    core_data,
    input  logic [KW-1:0]     core_klass,
    output logic              busy,
    output logic [CW-1:0]     done_cnt
);
    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N*B-1:0]  core_data_q, core_data_d;
    logic [KW-1:0]   out_klass_q, out_klass_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   done_cnt_q, done_cnt_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_data_d = core_data_q;
        out_klass_d = out_klass_q;
        out_valid_d = out_valid_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    core_data_d = bus.in_data;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = CNTW'(LAT - 1);
                state_d = RUN;
            end
            RUN: begin
                // klass is only trusted on the cycle the core has run exactly LAT cycles
                if (cnt_q == '0) begin
                    out_klass_d = core_klass;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CW'(1);
                    if (bus.in_valid) begin
                        core_data_d = bus.in_data;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        core_rst_d = (state_d == IDLE) || (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            core_data_q <= '0;
            out_klass_q <= '0;
            out_valid_q <= 1'b0;
            done_cnt_q  <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_data_q <= core_data_d;
            out_klass_q <= out_klass_d;
            out_valid_q <= out_valid_d;
            done_cnt_q  <= done_cnt_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
        end
    end

    // A new sample can enter while the finished result is being taken in the same cycle
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_klass = out_klass_q;
    assign core_rst      = core_rst_q;
    assign core_data     = core_data_q;
    assign busy          = busy_q;
    assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_bnn_seq_sched.sv
// Bench for bnn_seq_sched: a stand-in core that is only correct after exactly LAT cycles out of
// reset, and a transaction-level model of the scheduler's timing, handshakes and counter.
module tb_bnn_seq_sched;
    localparam int N     = 11;
    localparam int B     = 4;
    localparam int C     = 6;
    localparam int KW    = 3;
    localparam int LAT_A = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int golden(input logic [N*B-1:0] d);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(d[i*B +: B]);
        return s % C;
    endfunction

    function automatic int wrong(input logic [N*B-1:0] d, input logic [7:0] k);
        return (golden(d) + 1 + int'(k) % (C - 1)) % C;
    endfunction

    function automatic logic [N*B-1:0] rand44();
        return {12'($urandom), $urandom};
    endfunction

    // ---------------- DUT A: LAT=48, CW=16 ----------------
    bnn_seq_sched_if #(.N(N), .B(B), .KW(KW)) ifa ();
    logic           a_core_rst, a_busy;
    logic [N*B-1:0] a_core_data;
    logic [KW-1:0]  a_core_klass;
    logic [15:0]    a_done_cnt;
    logic [7:0]     ka = 8'd0;

    bnn_seq_sched #(.N(N), .B(B), .C(C), .LAT(LAT_A), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .core_rst(a_core_rst), .core_data(a_core_data), .core_klass(a_core_klass),
        .busy(a_busy), .done_cnt(a_done_cnt)
    );

    always @(posedge clk) ka <= a_core_rst ? 8'd0 : ((ka == 8'hff) ? ka : ka + 8'd1);
    assign a_core_klass = (ka == 8'(LAT_A - 1)) ? KW'(golden(a_core_data)) : KW'(wrong(a_core_data, ka));

    // ---------------- DUT B: LAT=1, CW=2 ----------------
    bnn_seq_sched_if #(.N(N), .B(B), .KW(KW)) ifb ();
    logic           b_core_rst, b_busy;
    logic [N*B-1:0] b_core_data;
    logic [KW-1:0]  b_core_klass;
    logic [1:0]     b_done_cnt;
    logic [7:0]     kb = 8'd0;

    bnn_seq_sched #(.N(N), .B(B), .C(C), .LAT(1), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .core_rst(b_core_rst), .core_data(b_core_data), .core_klass(b_core_klass),
        .busy(b_busy), .done_cnt(b_done_cnt)
    );

    always @(posedge clk) kb <= b_core_rst ? 8'd0 : ((kb == 8'hff) ? kb : kb + 8'd1);
    assign b_core_klass = (kb == 8'd0) ? KW'(golden(b_core_data)) : KW'(wrong(b_core_data, kb));

    // ---------------- reference model of DUT A ----------------
    bit             mon_on   = 1'b0;
    bit             m_busy   = 1'b0;
    logic [N*B-1:0] m_data   = '0;
    int             m_acc    = 0;
    int             m_done   = 0;
    int             m_accepts = 0;
    bit             t3_on    = 1'b0;
    int             t3_prev  = -1;

    always @(negedge clk) begin
        bit exp_ov;
        bit exp_ir;
        if (rst && mon_on) begin
            exp_ov = m_busy && (cyc >= m_acc + LAT_A + 1);
            exp_ir = !m_busy || (exp_ov && ifa.out_ready);
            check_eq("busy", 64'(a_busy), 64'(m_busy));
            check_eq("in_ready", 64'(ifa.in_ready), 64'(exp_ir));
            check_eq("core_rst", 64'(a_core_rst), 64'(!(m_busy && cyc >= m_acc + 1)));
            check_eq("out_valid", 64'(ifa.out_valid), 64'(exp_ov));
            check_eq("done_cnt", 64'(a_done_cnt), 64'(m_done % 65536));
            if (m_busy) check_eq("core_data", 64'(a_core_data), 64'(m_data));
            if (exp_ov && ifa.out_ready) begin
                check_eq("out_klass", 64'(ifa.out_klass), 64'(golden(m_data)));
                if (t3_on && t3_prev >= 0) check_eq("b2b_spacing", 64'(cyc - t3_prev), 64'(LAT_A + 2));
                t3_prev = cyc;
                m_done++;
                m_busy = 1'b0;
                $display("A result %0d: data=%h klass=%0d cycle=%0d", m_done, m_data, ifa.out_klass, cyc);
            end
            if (exp_ir && ifa.in_valid) begin
                m_busy = 1'b1;
                m_data = ifa.in_data;
                m_acc  = cyc + 1;
                m_accepts++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int target, input int budget);
        int k = 0;
        while (m_accepts < target && k < budget) begin tick(); k++; end
        check_eq("accept_timeout", 64'(m_accepts >= target), 64'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (m_done < target && k < budget) begin tick(); k++; end
        check_eq("done_timeout", 64'(m_done >= target), 64'd1);
    endtask

    initial begin
        int base;
        int k;
        int exp_b[5] = '{1, 2, 3, 0, 1};
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;

        // reset values
        #2 rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check_eq("rst_core_rst", 64'(a_core_rst), 64'd1);
        check_eq("rst_core_data", 64'(a_core_data), 64'd0);
        check_eq("rst_out_klass", 64'(ifa.out_klass), 64'd0);
        check_eq("rst_done_cnt", 64'(a_done_cnt), 64'd0);
        check_eq("rst_busy", 64'(a_busy), 64'd0);
        check_eq("rst_b_done_cnt", 64'(b_done_cnt), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        mon_on = 1'b1;

        // single sample, then input changes while busy
        tick();
        ifa.in_valid = 1'b1; ifa.in_data = 44'h123456789AB; ifa.out_ready = 1'b1;
        wait_accept(1, 5);
        ifa.in_valid = 1'b0; ifa.in_data = rand44();
        repeat (10) tick();
        ifa.in_data = rand44();
        wait_done(1, 100);
        check_eq("t1_done_cnt", 64'(a_done_cnt), 64'd1);

        // output stall with offered inputs that must be ignored
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = rand44();
        wait_accept(2, 5);
        ifa.in_valid = 1'b0;
        k = 0;
        while (!ifa.out_valid && k < 100) begin tick(); k++; end
        check_eq("t2_out_valid_timeout", 64'(ifa.out_valid), 64'd1);
        repeat (20) begin ifa.in_valid = 1'b1; ifa.in_data = rand44(); tick(); end
        check_eq("t2_done_hold", 64'(a_done_cnt), 64'd1);
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        wait_done(2, 5);
        check_eq("t2_done_cnt", 64'(a_done_cnt), 64'd2);

        // reset in the middle of RUN (cnt==20)
        ifa.in_valid = 1'b1; ifa.in_data = rand44();
        wait_accept(3, 5);
        ifa.in_valid = 1'b0;
        k = 0;
        while (cyc < m_acc + 28 && k < 60) begin tick(); k++; end
        check_eq("t4_reach_timeout", 64'(cyc >= m_acc + 28), 64'd1);
        #1 rst = 1'b0;
        m_busy = 1'b0; m_done = 0;
        #1;
        check_eq("t4_out_valid", 64'(ifa.out_valid), 64'd0);
        check_eq("t4_core_rst", 64'(a_core_rst), 64'd1);
        check_eq("t4_done_cnt", 64'(a_done_cnt), 64'd0);
        check_eq("t4_busy", 64'(a_busy), 64'd0);
        check_eq("t4_in_ready", 64'(ifa.in_ready), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();

        // back-to-back, 5 samples
        t3_prev = -1; t3_on = 1'b1; base = m_accepts; ifa.out_ready = 1'b1;
        k = 0;
        while (m_done < 5 && k < 400) begin
            ifa.in_valid = (m_accepts - base < 5);
            ifa.in_data  = rand44();
            tick();
            k++;
        end
        ifa.in_valid = 1'b0;
        check_eq("t3_timeout", 64'(m_done >= 5), 64'd1);
        check_eq("t3_done_cnt", 64'(a_done_cnt), 64'd5);
        t3_on = 1'b0;

        // randomized traffic
        base = m_done + 30;
        k = 0;
        while (m_done < base && k < 30 * 150) begin
            ifa.in_valid  = ($urandom_range(0, 2) != 0);
            ifa.in_data   = rand44();
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        check_eq("rand_timeout", 64'(m_done >= base), 64'd1);
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        k = 0;
        while (m_busy && k < 100) begin tick(); k++; end
        check_eq("drain_timeout", 64'(m_busy), 64'd0);

        // LAT=1, CW=2 instance
        for (int i = 0; i < 5; i++) begin
            logic [N*B-1:0] d;
            d = rand44();
            ifb.in_valid = 1'b1; ifb.in_data = d; ifb.out_ready = 1'b1;
            @(negedge clk);
            check_eq("b_in_ready", 64'(ifb.in_ready), 64'd1);
            @(posedge clk);
            #1 ifb.in_valid = 1'b0; ifb.in_data = rand44();
            @(negedge clk);
            check_eq("b_ov_start", 64'(ifb.out_valid), 64'd0);
            @(negedge clk);
            check_eq("b_ov_run", 64'(ifb.out_valid), 64'd0);
            @(negedge clk);
            check_eq("b_ov_done", 64'(ifb.out_valid), 64'd1);
            check_eq("b_klass", 64'(ifb.out_klass), 64'(golden(d)));
            @(posedge clk);
            #1;
            check_eq("b_done_cnt", 64'(b_done_cnt), 64'(exp_b[i]));
            check_eq("b_ov_clear", 64'(ifb.out_valid), 64'd0);
            $display("B result %0d: data=%h klass=%0d done_cnt=%0d", i + 1, d, golden(d), b_done_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
